// File: rtl/vend_pkg.sv
// Shared definitions for the change dispenser: amount width, coin encoding,
// coin value table and controller states.
package vend_pkg;

    localparam int AMT_W = 8;

    typedef enum logic [1:0] {
        COIN_1  = 2'd0,
        COIN_2  = 2'd1,
        COIN_5  = 2'd2,
        COIN_10 = 2'd3
    } coin_e;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        ISSUE,
        DONE,
        FAULT
    } state_e;

    function automatic logic [AMT_W-1:0] coin_value(input logic [1:0] sel);
        case (sel)
            2'd0:    return 8'd1;
            2'd1:    return 8'd2;
            2'd2:    return 8'd5;
            default: return 8'd10;
        endcase
    endfunction

endpackage

// File: rtl/coin_select.sv
// Picks the largest coin that fits the remaining amount and is still in stock.
module coin_select
    import vend_pkg::*;
(
    input  logic [AMT_W-1:0] remain,
    input  logic [AMT_W-1:0] stock_1,
    input  logic [AMT_W-1:0] stock_2,
    input  logic [AMT_W-1:0] stock_5,
    input  logic [AMT_W-1:0] stock_10,
    output logic             valid,
    output logic [1:0]       sel
);

    always_comb begin
        valid = 1'b1;
        sel   = COIN_1;
        if (remain >= coin_value(COIN_10) && stock_10 != '0) begin
            sel = COIN_10;
        end else if (remain >= coin_value(COIN_5) && stock_5 != '0) begin
            sel = COIN_5;
        end else if (remain >= coin_value(COIN_2) && stock_2 != '0) begin
            sel = COIN_2;
        end else if (remain >= coin_value(COIN_1) && stock_1 != '0) begin
            sel = COIN_1;
        end else begin
            valid = 1'b0;
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Greedy change pay-out controller: ejects coins one at a time from four
// stock counters and reports a shortfall when stock runs out.
module change_dispenser
    import vend_pkg::*;
#(
    parameter logic [AMT_W-1:0] STOCK_INIT = 8'd20,
    parameter logic [AMT_W-1:0] LOW_MARK   = 8'd4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             chg_valid,
    input  logic [AMT_W-1:0] change,
    output logic             chg_ready,
    output logic             coin_req,
    output logic [1:0]       coin_sel,
    input  logic             coin_ack,
    input  logic             refill_en,
    input  logic [1:0]       refill_sel,
    input  logic [AMT_W-1:0] refill_cnt,
    output logic             done,
    output logic             fault,
    output logic [AMT_W-1:0] shortfall,
    output logic [3:0]       stock_low
);

    state_e           state_q, state_d;
    logic [AMT_W-1:0] remain_q, remain_d;
    logic [AMT_W-1:0] short_q, short_d;
    logic [AMT_W-1:0] paid_rem;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       pick_sel;
    logic             pick_valid;
    logic             fault_q, fault_d;
    logic             rdy_q;
    logic [AMT_W-1:0] stock_q [4];
    logic [AMT_W-1:0] stock_d [4];

    function automatic logic [AMT_W-1:0] sat_amt(input logic [AMT_W:0] v);
        return v[AMT_W] ? '1 : v[AMT_W-1:0];
    endfunction

    coin_select u_coin_select (
        .remain   (remain_q),
        .stock_1  (stock_q[0]),
        .stock_2  (stock_q[1]),
        .stock_5  (stock_q[2]),
        .stock_10 (stock_q[3]),
        .valid    (pick_valid),
        .sel      (pick_sel)
    );

    // Cannot underflow: SELECT only issues coins no larger than remain_q.
    assign paid_rem = remain_q - coin_value(sel_q);

    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        sel_d    = sel_q;
        fault_d  = fault_q;
        short_d  = short_q;
        case (state_q)
            IDLE: begin
                if (chg_valid && chg_ready) begin
                    remain_d = change;
                    fault_d  = 1'b0;
                    short_d  = '0;
                    state_d  = (change == '0) ? DONE : SELECT;
                end
            end
            SELECT: begin
                if (pick_valid) begin
                    sel_d   = pick_sel;
                    state_d = ISSUE;
                end else begin
                    state_d = FAULT;
                end
            end
            ISSUE: begin
                if (coin_ack) begin
                    remain_d = paid_rem;
                    state_d  = (paid_rem == '0) ? DONE : SELECT;
                end
            end
            DONE: state_d = IDLE;
            FAULT: begin
                fault_d = 1'b1;
                short_d = remain_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Refill and an acknowledged ejection may hit the same counter in one cycle.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            stock_d[i] = sat_amt({1'b0, stock_q[i]}
                + ((refill_en && refill_sel == 2'(i)) ? {1'b0, refill_cnt} : '0)
                - {{AMT_W{1'b0}}, (state_q == ISSUE && coin_ack && sel_q == 2'(i))});
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            remain_q <= '0;
            sel_q    <= '0;
            fault_q  <= 1'b0;
            short_q  <= '0;
            rdy_q    <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                stock_q[i] <= STOCK_INIT;
            end
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            sel_q    <= sel_d;
            fault_q  <= fault_d;
            short_q  <= short_d;
            rdy_q    <= 1'b1;
            for (int i = 0; i < 4; i++) begin
                stock_q[i] <= stock_d[i];
            end
        end
    end

    always_comb begin
        stock_low = '0;
        for (int i = 0; i < 4; i++) begin
            stock_low[i] = (stock_q[i] < LOW_MARK);
        end
    end

    assign chg_ready = (state_q == IDLE) && rdy_q;
    assign coin_req  = (state_q == ISSUE);
    assign coin_sel  = sel_q;
    assign done      = (state_q == DONE);
    assign fault     = fault_q;
    assign shortfall = short_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: a greedy reference model queues the
// expected coins for each amount, and ejections are popped and compared.
module tb_change_dispenser;

    logic       clk = 1'b0;
    logic       rst;
    logic       chg_valid;
    logic [7:0] change;
    logic       chg_ready;
    logic       coin_req;
    logic [1:0] coin_sel;
    logic       coin_ack;
    logic       refill_en;
    logic [1:0] refill_sel;
    logic [7:0] refill_cnt;
    logic       done;
    logic       fault;
    logic [7:0] shortfall;
    logic [3:0] stock_low;

    int         vectors     = 0;
    int         miscompares = 0;
    logic [1:0] exp_q[$];
    int         mdl_stock[4];
    int         exp_short;

    always #5 clk = ~clk;

    change_dispenser dut (
        .clk        (clk),
        .rst        (rst),
        .chg_valid  (chg_valid),
        .change     (change),
        .chg_ready  (chg_ready),
        .coin_req   (coin_req),
        .coin_sel   (coin_sel),
        .coin_ack   (coin_ack),
        .refill_en  (refill_en),
        .refill_sel (refill_sel),
        .refill_cnt (refill_cnt),
        .done       (done),
        .fault      (fault),
        .shortfall  (shortfall),
        .stock_low  (stock_low)
    );

    function automatic int val(input int d);
        case (d)
            0:       return 1;
            1:       return 2;
            2:       return 5;
            default: return 10;
        endcase
    endfunction

    function automatic int sat255(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    // Greedy reference: queue the coins a correct dispenser ejects for amt.
    task automatic model_push(input int amt);
        int rem;
        int found;
        rem = amt;
        while (rem > 0) begin
            found = -1;
            for (int d = 3; d >= 0; d--) begin
                if (found < 0 && val(d) <= rem && mdl_stock[d] > 0) found = d;
            end
            if (found < 0) break;
            exp_q.push_back(2'(found));
            mdl_stock[found] = mdl_stock[found] - 1;
            rem = rem - val(found);
        end
        exp_short = rem;
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        chg_valid  = 1'b0;
        change     = 8'd0;
        coin_ack   = 1'b0;
        refill_en  = 1'b0;
        refill_sel = 2'd0;
        refill_cnt = 8'd0;
        exp_q.delete();
        exp_short  = 0;
        for (int d = 0; d < 4; d++) mdl_stock[d] = 20;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_txn(input logic [7:0] amt, input bit refill_on_ack);
        logic [1:0] exp_sel;
        bit         finished;
        int         hold;
        model_push(int'(amt));
        @(negedge clk);
        vectors++;
        if (chg_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_before amt=%0d: got %b want 1", amt, chg_ready);
        end
        chg_valid = 1'b1;
        change    = amt;
        @(negedge clk);
        chg_valid = 1'b0;
        if (amt == 8'd0) begin
            vectors++;
            if (done !== 1'b1 || coin_req !== 1'b0 || fault !== 1'b0 || shortfall !== 8'd0) begin
                miscompares++;
                $display("FAIL zero_done: got done=%b req=%b fault=%b short=%0d want 1 0 0 0",
                         done, coin_req, fault, shortfall);
            end
            @(negedge clk);
            vectors++;
            if (done !== 1'b0 || chg_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL zero_ready: got done=%b ready=%b want 0 1", done, chg_ready);
            end
        end else begin
            vectors++;
            if (coin_req !== 1'b0 || chg_ready !== 1'b0 || fault !== 1'b0) begin
                miscompares++;
                $display("FAIL select_cycle amt=%0d: got req=%b ready=%b fault=%b want 0 0 0",
                         amt, coin_req, chg_ready, fault);
            end
            @(negedge clk);
            if (exp_q.size() != 0) begin
                vectors++;
                if (coin_req !== 1'b1) begin
                    miscompares++;
                    $display("FAIL first_req_latency amt=%0d: got req=%b want 1", amt, coin_req);
                end
            end
            finished = 1'b0;
            for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
                if (done === 1'b1) begin
                    finished = 1'b1;
                    vectors++;
                    if (exp_q.size() != 0 || exp_short != 0 || fault !== 1'b0 || shortfall !== 8'd0) begin
                        miscompares++;
                        $display("FAIL done_end amt=%0d: got pending=%0d fault=%b short=%0d want pending=0 short=%0d",
                                 amt, exp_q.size(), fault, shortfall, exp_short);
                    end
                    @(negedge clk);
                    vectors++;
                    if (done !== 1'b0 || chg_ready !== 1'b1) begin
                        miscompares++;
                        $display("FAIL done_pulse: got done=%b ready=%b want 0 1", done, chg_ready);
                    end
                end else if (fault === 1'b1) begin
                    finished = 1'b1;
                    vectors++;
                    if (exp_short == 0 || shortfall !== 8'(exp_short) || exp_q.size() != 0 || chg_ready !== 1'b1) begin
                        miscompares++;
                        $display("FAIL fault_end amt=%0d: got short=%0d pending=%0d ready=%b want short=%0d pending=0 ready=1",
                                 amt, shortfall, exp_q.size(), chg_ready, exp_short);
                    end
                    @(negedge clk);
                    vectors++;
                    if (fault !== 1'b1 || shortfall !== 8'(exp_short)) begin
                        miscompares++;
                        $display("FAIL fault_hold: got fault=%b short=%0d want 1 %0d", fault, shortfall, exp_short);
                    end
                end else begin
                    if (coin_req === 1'b1) begin
                        vectors++;
                        if (exp_q.size() == 0) begin
                            miscompares++;
                            $display("FAIL extra_coin amt=%0d: got sel=%0d want no coin", amt, coin_sel);
                            exp_sel = coin_sel;
                        end else begin
                            exp_sel = exp_q.pop_front();
                            if (coin_sel !== exp_sel) begin
                                miscompares++;
                                $display("FAIL coin_sel amt=%0d: got %0d want %0d", amt, coin_sel, exp_sel);
                            end
                        end
                        hold = int'($urandom_range(0, 2));
                        for (int h = 0; h < hold; h++) begin
                            @(negedge clk);
                            vectors++;
                            if (coin_req !== 1'b1 || coin_sel !== exp_sel) begin
                                miscompares++;
                                $display("FAIL coin_hold: got req=%b sel=%0d want 1 %0d", coin_req, coin_sel, exp_sel);
                            end
                        end
                        coin_ack = 1'b1;
                        if (refill_on_ack) begin
                            refill_en    = 1'b1;
                            refill_sel   = 2'd3;
                            refill_cnt   = 8'd250;
                            mdl_stock[3] = sat255(mdl_stock[3] + 250);
                        end
                    end
                    @(negedge clk);
                    coin_ack  = 1'b0;
                    refill_en = 1'b0;
                end
            end
            if (!finished) begin
                vectors++;
                miscompares++;
                $display("FAIL timeout amt=%0d: got no done/fault want one within budget", amt);
            end
        end
        for (int d = 0; d < 4; d++) begin
            vectors++;
            if (dut.stock_q[d] !== 8'(mdl_stock[d]) || stock_low[d] !== (mdl_stock[d] < 4)) begin
                miscompares++;
                $display("FAIL stock[%0d] after amt=%0d: got %0d low=%b want %0d low=%b",
                         d, amt, dut.stock_q[d], stock_low[d], mdl_stock[d], (mdl_stock[d] < 4));
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        vectors++;
        if (coin_req !== 1'b0 || done !== 1'b0 || fault !== 1'b0 || shortfall !== 8'd0 || coin_sel !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got req=%b done=%b fault=%b short=%0d sel=%0d want all 0",
                     coin_req, done, fault, shortfall, coin_sel);
        end
        do_reset();
        vectors++;
        if (chg_ready !== 1'b1 || stock_low !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_ready: got ready=%b low=%b want 1 0000", chg_ready, stock_low);
        end
    endtask

    task automatic test_greedy();
        run_txn(8'd18, 1'b0);
    endtask

    task automatic test_zero();
        run_txn(8'd0, 1'b0);
    endtask

    task automatic test_ack_ignored();
        @(negedge clk);
        coin_ack = 1'b1;
        @(negedge clk);
        coin_ack = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            vectors++;
            if (dut.stock_q[d] !== 8'(mdl_stock[d])) begin
                miscompares++;
                $display("FAIL ack_ignored stock[%0d]: got %0d want %0d", d, dut.stock_q[d], mdl_stock[d]);
            end
        end
        vectors++;
        if (done !== 1'b0 || chg_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ack_ignored_state: got done=%b ready=%b want 0 1", done, chg_ready);
        end
    endtask

    task automatic test_refill_idle();
        @(negedge clk);
        refill_en  = 1'b1;
        refill_sel = 2'd0;
        refill_cnt = 8'd250;
        mdl_stock[0] = sat255(mdl_stock[0] + 250);
        @(negedge clk);
        refill_sel = 2'd2;
        refill_cnt = 8'd3;
        mdl_stock[2] = sat255(mdl_stock[2] + 3);
        @(negedge clk);
        refill_en = 1'b0;
        for (int d = 0; d < 4; d++) begin
            vectors++;
            if (dut.stock_q[d] !== 8'(mdl_stock[d])) begin
                miscompares++;
                $display("FAIL refill stock[%0d]: got %0d want %0d", d, dut.stock_q[d], mdl_stock[d]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] amts [6];
        amts = '{8'd33, 8'd1, 8'd0, 8'd99, 8'd7, 8'd16};
        for (int i = 0; i < 6; i++) run_txn(amts[i], 1'b0);
        for (int i = 0; i < 4; i++) run_txn(8'($urandom_range(1, 40)), 1'b0);
    endtask

    task automatic test_skip5();
        do_reset();
        for (int i = 0; i < 20; i++) run_txn(8'd5, 1'b0);
        run_txn(8'd7, 1'b0);
    endtask

    task automatic test_fault();
        do_reset();
        run_txn(8'd200, 1'b0);
        run_txn(8'd100, 1'b0);
        run_txn(8'd40, 1'b0);
        run_txn(8'd17, 1'b0);
        run_txn(8'd5, 1'b0);
        run_txn(8'd0, 1'b0);
    endtask

    task automatic test_refill_on_ack();
        do_reset();
        run_txn(8'd10, 1'b1);
    endtask

    task automatic test_reset_mid_issue();
        bit seen;
        do_reset();
        @(negedge clk);
        chg_valid = 1'b1;
        change    = 8'd10;
        @(negedge clk);
        chg_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5 && !seen; i++) begin
            @(negedge clk);
            if (coin_req === 1'b1) seen = 1'b1;
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL mid_issue_req: got req=%b want 1", coin_req);
        end
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if (coin_req !== 1'b0 || done !== 1'b0 || fault !== 1'b0 || shortfall !== 8'd0) begin
            miscompares++;
            $display("FAIL async_reset: got req=%b done=%b fault=%b short=%0d want 0 0 0 0",
                     coin_req, done, fault, shortfall);
        end
        for (int d = 0; d < 4; d++) begin
            vectors++;
            if (dut.stock_q[d] !== 8'd20) begin
                miscompares++;
                $display("FAIL async_reset stock[%0d]: got %0d want 20", d, dut.stock_q[d]);
            end
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (done !== 1'b0 || fault !== 1'b0 || coin_req !== 1'b0 || chg_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL post_reset: got done=%b fault=%b req=%b ready=%b want 0 0 0 1",
                         done, fault, coin_req, chg_ready);
            end
        end
    endtask

    initial begin
        rst        = 1'b0;
        chg_valid  = 1'b0;
        change     = 8'd0;
        coin_ack   = 1'b0;
        refill_en  = 1'b0;
        refill_sel = 2'd0;
        refill_cnt = 8'd0;
        test_reset();
        test_greedy();
        test_zero();
        test_ack_ignored();
        test_refill_idle();
        test_back_to_back();
        test_skip5();
        test_fault();
        test_refill_on_ack();
        test_reset_mid_issue();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 The module SHALL have parameter STOCK_INIT, default 8'd20, giving the reset value of every coin stock counter.
REQ-002 The module SHALL have parameter LOW_MARK, default 8'd4, giving the stock level below which the stock_low bit for that denomination is set.
REQ-003 clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 chg_valid  in  1  a change amount is presented on change.
REQ-006 change  in  8  change amount to pay out, in currency units (0..255).
REQ-007 chg_ready  out  1  the block can accept a change amount (high only in IDLE).
REQ-008 coin_req  out  1  request the eject mechanism to release one coin.
REQ-009 coin_sel  out  2  denomination to eject: 0=1, 1=2, 2=5, 3=10 units.
REQ-010 coin_ack  in  1  one-cycle pulse: the mechanism has released the requested coin.
REQ-011 refill_en  in  1  add refill_cnt coins to the stock selected by refill_sel.
REQ-012 refill_sel  in  2  denomination being refilled (same encoding as coin_sel).
REQ-013 refill_cnt  in  8  number of coins added.
REQ-014 done  out  1  one-cycle pulse: the full amount has been paid out.
REQ-015 fault  out  1  stock cannot cover the remainder; held high until the next accepted amount.
REQ-016 shortfall  out  8  unpaid remainder when fault is high; 0 otherwise.
REQ-017 stock_low  out  4  bit i is high when the stock of denomination i is below LOW_MARK.

Function
REQ-018 FSM states SHALL be IDLE, SELECT, ISSUE, DONE and FAULT.
- IDLE: chg_ready=1.
- On chg_valid&&chg_ready, latch change into remain; fault and shortfall clear in the same edge.
- Next state: DONE if change==0, else SELECT.
REQ-019 SELECT SHALL last exactly one cycle.
- Choose the largest denomination d with value(d)<=remain and stock[d]>0; go to ISSUE.
- If no such d exists, go to FAULT.
REQ-020 ISSUE SHALL hold coin_req=1 and a stable coin_sel until coin_ack.
- On coin_ack: remain -= value(d) and stock[d] -= 1.
- Next state: DONE if the new remain==0, else SELECT.
REQ-021 coin_ack outside ISSUE SHALL be ignored, with no change to remain or stock.
REQ-022 First coin_req SHALL assert two cycles after the acceptance edge: accept at N, SELECT during N+1, coin_req high at N+2.
REQ-023 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-024 FAULT SHALL last one cycle.
- Set fault=1 and shortfall=remain; both hold through IDLE until the next acceptance.
- Return to IDLE.
REQ-025 Refill SHALL be accepted in any state: stock[refill_sel] += refill_cnt, saturating at 255.
REQ-026 If refill and coin_ack hit the same denomination in one cycle, the result SHALL be min(stock + refill_cnt - 1, 255).
REQ-027 A refill landing during SELECT SHALL NOT affect that SELECT decision; only the registered stock values are used.
REQ-028 stock_low SHALL be a combinational compare of the registered stocks against LOW_MARK.
REQ-029 remain SHALL never underflow, because SELECT only chooses d with value(d)<=remain.

Reset
REQ-030 While rst=0, asynchronously:
- state=IDLE, remain=0, every stock=STOCK_INIT.
- coin_req=0, coin_sel=0, done=0, fault=0, shortfall=0.
- chg_ready SHALL go high on the first clock after rst deasserts.
REQ-031 A reset during ISSUE SHALL drop coin_req immediately and discard the unpaid remainder; no done or fault is produced.

Structure
REQ-032 Shared package vend_pkg SHALL hold:
- the denomination encoding and the value table (1, 2, 5, 10);
- the FSM state enum;
- the 8-bit amount width constant.
REQ-033 The largest-coin choice SHALL be a combinational sub-module coin_select.
- Inputs: remain and the four stock counters.
- Outputs: valid and sel.

Verification
REQ-034 All stocks 20, change=18 -> coins 10, 5, 2, 1, then a done pulse; stocks become 19/19/19/19.
REQ-035 change=0 accepted at cycle N -> done at N+1, no coin_req, chg_ready high at N+2.
REQ-036 stock[5]=0 and others 20, change=7 -> coins 2, 2, 2, 1, then done.
REQ-037 Only stock[1]=3 and others 0, change=5 -> three 1s, then fault=1 and shortfall=2 held; a new change=0 -> fault clears.
REQ-038 During ISSUE for denomination 10: refill_en with refill_sel=3 and refill_cnt=250 in the same cycle as coin_ack, stock[10]=20 -> stock 255.
REQ-039 Assert rst mid-ISSUE -> coin_req low with no clock; all stocks = STOCK_INIT; no done or fault.
